// File: rtl/d_fifo_reader_pkg.sv
// d_fifo_reader shared types: source tags, round-robin pointer
// encoding and destination-bit helper.
package d_fifo_reader_pkg;

  localparam logic SRC_D0 = 1'b0;
  localparam logic SRC_D1 = 1'b1;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int CNT_WIDTH_DEF  = 5;

  typedef enum logic {
    PTR_D0 = 1'b0,
    PTR_D1 = 1'b1
  } rr_ptr_e;

  function automatic int dest_bit(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/d_fifo_reader_if.sv
// FIFO-side bundle of d_fifo_reader: empty flags, read data
// and pop strobes for destinations D0 and D1.
interface d_fifo_reader_if #(
  parameter int DATA_WIDTH = 6
) ();

  logic                  D0_empty;
  logic                  D1_empty;
  logic [DATA_WIDTH-1:0] data_out_D0;
  logic [DATA_WIDTH-1:0] data_out_D1;
  logic                  D0_pop;
  logic                  D1_pop;

  modport master (
    input  D0_empty,
    input  D1_empty,
    input  data_out_D0,
    input  data_out_D1,
    output D0_pop,
    output D1_pop
  );

  modport slave (
    output D0_empty,
    output D1_empty,
    output data_out_D0,
    output data_out_D1,
    input  D0_pop,
    input  D1_pop
  );

endinterface

// File: rtl/reader_rr_arbiter.sv
// Two-way round-robin pop arbiter with registered one-hot
// grant; a FIFO popped last cycle is never granted again.
module reader_rr_arbiter
  import d_fifo_reader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic [1:0] last_pop_i,
  output logic [1:0] grant_o
);

  rr_ptr_e    ptr_q, ptr_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] elig;

  // empty flag lags a pop by one edge, so mask last pop
  assign elig = req_i & ~last_pop_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= PTR_D0;
      grant_q <= 2'b00;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    grant_d = 2'b00;
    unique case (1'b1)
      (elig == 2'b11): begin
        if (ptr_q == PTR_D0) begin
          grant_d = 2'b01;
          ptr_d   = PTR_D1;
        end else begin
          grant_d = 2'b10;
          ptr_d   = PTR_D0;
        end
      end
      (elig == 2'b01): begin
        grant_d = 2'b01;
        ptr_d   = PTR_D1;
      end
      (elig == 2'b10): begin
        grant_d = 2'b10;
        ptr_d   = PTR_D0;
      end
      default: ;
    endcase
  end

  assign grant_o = grant_q;

endmodule

// File: rtl/d_fifo_reader.sv
// Pop controller merging D0/D1 FIFOs into one tagged stream.
// Define D_FIFO_READER_DEST_CHECK_EN to enable error_dest.
module d_fifo_reader
  import d_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  d_fifo_reader_if.master       fifo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  src_out,
  output logic [CNT_WIDTH-1:0]  cnt_D0,
  output logic [CNT_WIDTH-1:0]  cnt_D1,
  output logic                  error_dest
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [1:0]            req;
  logic [1:0]            grant;
  logic [DATA_WIDTH-1:0] cap_data;

  logic                  pend_vld_q, pend_vld_d;
  logic                  pend_src_q, pend_src_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  src_q, src_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

  assign req[0] = enable & ~fifo.D0_empty;
  assign req[1] = enable & ~fifo.D1_empty;

  reader_rr_arbiter u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .last_pop_i (grant),
    .grant_o    (grant)
  );

  assign fifo.D0_pop = grant[0];
  assign fifo.D1_pop = grant[1];

  assign cap_data = (pend_src_q == SRC_D1) ? fifo.data_out_D1
                                           : fifo.data_out_D0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld_q <= 1'b0;
      pend_src_q <= SRC_D0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      src_q      <= SRC_D0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_src_q <= pend_src_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      src_q      <= src_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  always_comb begin
    pend_vld_d = |grant;
    pend_src_d = grant[1] ? SRC_D1 : SRC_D0;
    valid_d    = pend_vld_q;
    data_d     = data_q;
    src_d      = src_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    if (pend_vld_q) begin
      data_d = cap_data;
      src_d  = pend_src_q;
      // counters saturate instead of wrapping
      if (pend_src_q == SRC_D0) begin
        if (cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_ONE;
      end else begin
        if (cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_ONE;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign src_out   = src_q;
  assign cnt_D0    = cnt0_q;
  assign cnt_D1    = cnt1_q;

`ifdef D_FIFO_READER_DEST_CHECK_EN
  localparam int DEST_BIT = dest_bit(DATA_WIDTH);

  logic err_q, err_d;

  always_comb begin
    err_d = pend_vld_q & (cap_data[DEST_BIT] != pend_src_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign error_dest = err_q;
`else
  assign error_dest = 1'b0;
`endif

endmodule

// File: tb/tb_d_fifo_reader.sv
// Self-checking bench for d_fifo_reader: FIFO models, vector
// table of expected output words and a scoreboard queue.
module tb_d_fifo_reader;
  import d_fifo_reader_pkg::*;

  localparam int DW = 6;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          src_out;
  logic [CW-1:0] cnt_D0;
  logic [CW-1:0] cnt_D1;
  logic          error_dest;

  d_fifo_reader_if #(.DATA_WIDTH(DW)) fif ();

  d_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo       (fif),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .src_out    (src_out),
    .cnt_D0     (cnt_D0),
    .cnt_D1     (cnt_D1),
    .error_dest (error_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            scen;
    logic [DW-1:0] data;
    logic          src;
    int            gap;
  } vec_t;

  vec_t          tbl[$];
  vec_t          exp_q[$];
  vec_t          cur;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            n_pass = 0;
  int            n_chk = 0;
  int            cyc = 0;
  int            last_evt = 0;
  int            npops = 0;
  bit            first_pend = 1'b0;
  logic          e_err;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // FIFO models: read data appears the cycle after a pop
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fif.D0_pop && q0.size() > 0) fif.data_out_D0 <= q0.pop_front();
    if (fif.D1_pop && q1.size() > 0) fif.data_out_D1 <= q1.pop_front();
  end

  always @(negedge clk) begin
    fif.D0_empty <= (q0.size() == 0);
    fif.D1_empty <= (q1.size() == 0);
  end

  always @(negedge clk) begin
    if (fif.D0_pop || fif.D1_pop) begin
      npops++;
      if (first_pend) begin
        last_evt   = cyc;
        first_pend = 1'b0;
      end
      chk("one_pop", int'(fif.D0_pop & fif.D1_pop), 0);
      chk("no_underflow",
          int'((fif.D0_pop && q0.size() == 0) ||
               (fif.D1_pop && q1.size() == 0)), 0);
    end
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        cur = exp_q.pop_front();
`ifdef D_FIFO_READER_DEST_CHECK_EN
        e_err = cur.data[DW-1] ^ cur.src;
`else
        e_err = 1'b0;
`endif
        chk("data_out", int'(data_out), int'(cur.data));
        chk("src_out", int'(src_out), int'(cur.src));
        chk("gap", cyc - last_evt, cur.gap);
        chk("error_dest", int'(error_dest), int'(e_err));
        last_evt = cyc;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    first_pend = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    first_pend = 1'b1;
    enable     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++)
      @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic load(input int s);
    case (s)
      0: begin
        q0.push_back(6'd1); q0.push_back(6'd2);
        q0.push_back(6'd3); q0.push_back(6'd4);
      end
      1: begin
        q0.push_back(6'd1);  q0.push_back(6'd2);
        q1.push_back(6'd33); q1.push_back(6'd34);
      end
      default: q0.push_back(6'b100011);
    endcase
  endtask

  int            e0[3] = '{4, 2, 1};
  int            e1[3] = '{0, 2, 0};
  int            p;
  logic [DW-1:0] w;

  initial begin
    tbl.push_back('{0, 6'd1, 1'b0, 2});
    tbl.push_back('{0, 6'd2, 1'b0, 2});
    tbl.push_back('{0, 6'd3, 1'b0, 2});
    tbl.push_back('{0, 6'd4, 1'b0, 2});
    tbl.push_back('{1, 6'd1, 1'b0, 2});
    tbl.push_back('{1, 6'd33, 1'b1, 1});
    tbl.push_back('{1, 6'd2, 1'b0, 1});
    tbl.push_back('{1, 6'd34, 1'b1, 1});
    tbl.push_back('{2, 6'b100011, 1'b0, 2});

    do_reset();
    chk("rst_data", int'(data_out), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_src", int'(src_out), 0);
    chk("rst_cnt0", int'(cnt_D0), 0);
    chk("rst_cnt1", int'(cnt_D1), 0);
    chk("rst_err", int'(error_dest), 0);
    chk("rst_pop0", int'(fif.D0_pop), 0);
    chk("rst_pop1", int'(fif.D1_pop), 0);

    for (int s = 0; s < 3; s++) begin
      do_reset();
      load(s);
      foreach (tbl[i]) if (tbl[i].scen == s) exp_q.push_back(tbl[i]);
      release_rst();
      drain(60);
      chk($sformatf("cnt0_s%0d", s), int'(cnt_D0), e0[s]);
      chk($sformatf("cnt1_s%0d", s), int'(cnt_D1), e1[s]);
    end

    do_reset();
    for (int i = 0; i < 40; i++) begin
      w = DW'(32 + (i % 32));
      q1.push_back(w);
      exp_q.push_back('{3, w, 1'b1, 2});
    end
    release_rst();
    drain(200);
    chk("sat_cnt1", int'(cnt_D1), 31);
    chk("sat_cnt0", int'(cnt_D0), 0);

    do_reset();
    q0.push_back(6'd7); q0.push_back(6'd8); q0.push_back(6'd9);
    exp_q.push_back('{4, 6'd7, 1'b0, 2});
    release_rst();
    for (int i = 0; i < 20 && !fif.D0_pop; i++) @(negedge clk);
    chk("en_pop_seen", int'(fif.D0_pop), 1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    p = npops;
    drain(10);
    repeat (10) @(posedge clk);
    chk("en_no_pops", npops - p, 0);
    chk("en_cnt0", int'(cnt_D0), 1);

    do_reset();
    q0.push_back(6'd10); q0.push_back(6'd11);
    release_rst();
    for (int i = 0; i < 20 && !fif.D0_pop; i++) @(negedge clk);
    chk("rf_pop_seen", int'(fif.D0_pop), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("rf_pop_clr", int'(fif.D0_pop), 0);
    chk("rf_valid", int'(valid_out), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rf_valid_hold", int'(valid_out), 0);
    chk("rf_cnt0", int'(cnt_D0), 0);
    chk("rf_cnt1", int'(cnt_D1), 0);

    do_reset();
    q0.push_back(6'd5);
    q1.push_back(6'd37);
    exp_q.push_back('{5, 6'd5, 1'b0, 2});
    exp_q.push_back('{5, 6'd37, 1'b1, 1});
    release_rst();
    drain(40);
    chk("rr_cnt0", int'(cnt_D0), 1);
    chk("rr_cnt1", int'(cnt_D1), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/d_fifo_reader.md
# d_fifo_reader

Consumer-side pop controller for the two destination FIFOs (D0, D1) at the output of the transmission-layer logic. It issues pops with round-robin arbitration, never underflows a FIFO, and merges both streams into one registered output word with valid and source tag. Per-destination word counters and an optional destination-bit check give the verification bench and downstream logic a checkable stream.

## Interface
- DATA_WIDTH, 6: word width; bit DATA_WIDTH-1 is the destination bit (0 = D0, 1 = D1).
- CNT_WIDTH, 5: width of the per-destination word counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; all state cleared while 0.
- enable  input  1  permits new pops while 1.
- D0_empty  input  1  D0 FIFO empty flag.
- D1_empty  input  1  D1 FIFO empty flag.
- data_out_D0  input  DATA_WIDTH  D0 FIFO read data, valid one cycle after its pop.
- data_out_D1  input  DATA_WIDTH  D1 FIFO read data, valid one cycle after its pop.
- D0_pop  output  1  pop strobe to D0 FIFO.
- D1_pop  output  1  pop strobe to D1 FIFO.
- data_out  output  DATA_WIDTH  merged word.
- valid_out  output  1  data_out valid this cycle.
- src_out  output  1  source of data_out (0 = D0, 1 = D1).
- cnt_D0  output  CNT_WIDTH  words delivered from D0, saturating.
- cnt_D1  output  CNT_WIDTH  words delivered from D1, saturating.
- error_dest  output  1  destination-bit mismatch on the current valid word.

## Operation
- Reset values: D0_pop=0, D1_pop=0, data_out=0, valid_out=0, src_out=0, cnt_D0=0, cnt_D1=0, error_dest=0. Round-robin pointer points to D0. Pipeline-pending flag is cleared.
- Pops are registered outputs. At most one pop is asserted per cycle.
- Eligibility of FIFO Dx in cycle t requires all of:
  - enable=1,
  - Dx_empty=0,
  - Dx was not popped in cycle t-1.
  - Rationale: the empty flag lags a pop by one edge, so this prevents underflow.
- Arbitration states: PTR_D0 and PTR_D1.
  - If both FIFOs are eligible, pop the FIFO named by the pointer, then move the pointer to the other FIFO.
  - If only one is eligible, pop it and set the pointer to the other FIFO.
  - If neither is eligible, no pop and the pointer holds.
- Pipeline: the pop source is registered as pending. In the following cycle the FIFO data is valid, and at that cycle's closing edge it is captured into data_out, with src_out = source and valid_out=1.
- Counters:
  - cnt_D0 increments on every captured D0 word; cnt_D1 likewise for D1.
  - Both saturate at 2^CNT_WIDTH-1; no wrap.
- enable falling mid-stream: no new pops from that cycle on; an already-issued pop still completes and produces its valid_out.

## Timing
- Latency: pop asserted in cycle t → FIFO data in t+1 → valid_out/data_out in t+2.
- Throughput:
  - Both FIFOs non-empty: one word per cycle, alternating D0, D1, D0, …
  - Single non-empty FIFO: one word per two cycles.
- valid_out is a single-cycle pulse per word. data_out holds its last value while valid_out=0.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). In-flight words are discarded and not counted. The first pop after reset release occurs no earlier than the first rising edge with reset=1.
- Simultaneous empty-deassert on both FIFOs right after reset: D0 is served first.

## Configuration
- Macro: D_FIFO_READER_DEST_CHECK_EN.
- Defined: error_dest is registered alongside valid_out. It is 1 when the captured word's bit DATA_WIDTH-1 differs from src_out, and 0 when valid_out=0.
- Undefined: error_dest is tied to 0 and the comparison logic is absent. All other behaviour is identical.

## Structure
- Shared package d_fifo_reader_pkg holds:
  - source constants SRC_D0=1'b0, SRC_D1=1'b1,
  - round-robin state encoding PTR_D0/PTR_D1,
  - the DEST_BIT index expression (DATA_WIDTH-1).
- One sub-module, reader_rr_arbiter: two request bits plus last-pop bits in, registered one-hot grant and pointer state out.
- The top level holds the data pipeline, counters and destination check.

## Test plan
- Reset, then D0 holds words 000001..000100, D1 empty, enable=1 → D0_pop every other cycle. data_out sequence 000001, 000010, 000011, 000100, one word per two cycles, src_out=0. cnt_D0=4, cnt_D1=0.
- D0 holds 000001, 000010 and D1 holds 100001, 100010, both present at reset release → output order 000001, 100001, 000010, 100010 on consecutive cycles. First valid_out occurs 2 cycles after the first D0_pop.
- Continuous non-empty D1 for 40 words → cnt_D1 saturates at 31 and stays there.
- With D_FIFO_READER_DEST_CHECK_EN defined, D0 supplies 100011 → error_dest=1 in the same cycle as valid_out and src_out=0. Rebuild with the macro undefined → error_dest stays 0.
- enable dropped in the cycle after a D0_pop → that word still appears with valid_out 1 cycle later; no further pops while enable=0.
- reset driven low while a pop is in flight → valid_out stays 0, counters read 0. After release, arbitration restarts at D0.
